reversible_divider8: RTL and testbench

Sequential restoring divider for the MAC8 datapath; the inverse operation of the multiply-accumulate path.
Each iteration does a trial subtraction on a ripple chain of reversible_full_adder cells wired as subtractors.
Takes an unsigned dividend/divisor pair on a start strobe, iterates one quotient bit per clock, and returns quotient and remainder with a done pulse.
Sits beside the MAC8 accumulator and is driven by the same top-level control.

---
 rtl/reversible_divider8.sv | 193 +++++++++++++++++++
 tb/tb_reversible_divider8.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reversible_divider8.sv
// Sequential restoring divider built on a ripple chain of reversible (Peres-gate)
// full adders. It produces one quotient bit per clock and returns quotient and remainder with a done pulse.

module peres_gate (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic p_o,
  output logic q_o,
  output logic r_o
);
  assign p_o = a_i;
  assign q_o = a_i ^ b_i;
  assign r_o = (a_i & b_i) ^ c_i;
endmodule

// Two cascaded Peres gates form a full adder. ctrl_i = 0 selects add mode.
module reversible_full_adder (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       cin_i,
  input  logic       ctrl_i,
  output logic       sum_o,
  output logic       cout_o,
  output logic [1:0] garbage_o
);
  logic g0_p, g0_q, g0_r;
  logic g1_p;

  peres_gate u_g0 (
    .a_i (a_i),
    .b_i (b_i),
    .c_i (ctrl_i),
    .p_o (g0_p),
    .q_o (g0_q),
    .r_o (g0_r)
  );

  peres_gate u_g1 (
    .a_i (g0_q),
    .b_i (cin_i),
    .c_i (g0_r),
    .p_o (g1_p),
    .q_o (sum_o),
    .r_o (cout_o)
  );

  assign garbage_o = {g1_p, g0_p};
endmodule

module reversible_divider8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  // Iteration datapath. The top bit of P is always 0 between iterations,
  // because the kept partial remainder is smaller than the divisor.
  logic [WIDTH:0]       p_sh;
  logic [WIDTH-1:0]     q_sh;
  logic [WIDTH:0]       d_inv;
  logic [WIDTH:0]       trial;
  logic [WIDTH+1:0]     carry;
  logic [2*WIDTH+1:0]   garbage;
  logic                 no_borrow;
  logic [WIDTH:0]       p_next;
  logic [WIDTH-1:0]     q_next;
  logic                 unused_garbage;

  assign p_sh     = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign q_sh     = q_q << 1;
  assign d_inv    = ~{1'b0, d_q};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
    reversible_full_adder u_rfa (
      .a_i       (p_sh[i]),
      .b_i       (d_inv[i]),
      .cin_i     (carry[i]),
      .ctrl_i    (1'b0),
      .sum_o     (trial[i]),
      .cout_o    (carry[i+1]),
      .garbage_o (garbage[2*i+1:2*i])
    );
  end

  assign no_borrow      = carry[WIDTH+1];
  assign p_next         = no_borrow ? trial : p_sh;
  assign q_next         = {q_sh[WIDTH-1:1], no_borrow};
  assign unused_garbage = ^{garbage, p_q[WIDTH]};

  // NOTE: every _d signal gets a default hold value first, so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          d_d   = divisor;
          q_d   = dividend;
          p_d   = '0;
          cnt_d = '0;
          if (divisor == '0) begin
            state_d = S_DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        p_d   = p_next;
        q_d   = q_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
          quot_d  = q_next;
          rem_d   = p_next[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Status is masked by rst so it cannot assert during the reset cycle itself.
  assign busy        = (state_q != S_IDLE) && !rst;
  assign done        = (state_q == S_DONE) && !rst;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_reversible_divider8.sv
// Self-checking bench for reversible_divider8.
// Expected results are queued when a start is driven and then popped at done.

module tb_reversible_divider8;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  reversible_divider8 #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic exp_t model(input logic [7:0] dd, input logic [7:0] dv);
    exp_t e;
    if (dv == 8'd0) e = '{q: 8'hFF, r: dd, z: 1'b1};
    else            e = '{q: dd / dv, r: dd % dv, z: 1'b0};
    return e;
  endfunction

  // Drives one start cycle and queues the expected result. It returns #1 after the sampling edge.
  task automatic launch(input logic [7:0] dd, input logic [7:0] dv, input bit hold);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    sb.push_back(model(dd, dv));
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb.size() == 0) e = 'x;
    else                e = sb.pop_front();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      errors++;
      $display("FAIL reset_hold: got busy=%b done=%b q=%0d r=%0d z=%b expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b done=%b q=%0d r=%0d z=%b expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_basic;
    int n; bit ok; exp_t e;
    launch(8'd100, 8'd7, 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: got busy=%b done=%b expected busy=1 done=0", busy, done);
    end
    wait_done(30, n, ok);
    checks++;
    if (!ok || n != 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d more cycles (seen=%0b) expected 8", n, ok);
    end
    pop_exp(e);
    checks++;
    if ({quotient, remainder, div_by_zero} !== e) begin
      errors++;
      $display("FAIL basic_result: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.z);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, quotient, remainder, div_by_zero} !== {2'b00, e}) begin
        errors++;
        $display("FAIL basic_hold%0d: got busy=%b done=%b q=%0d r=%0d z=%b expected idle q=%0d r=%0d z=%b",
                 i, busy, done, quotient, remainder, div_by_zero, e.q, e.r, e.z);
      end
    end
  endtask

  task automatic test_boundaries;
    int n; bit ok; exp_t e;
    logic [7:0] bdd [5] = '{8'd255, 8'd255, 8'd5,   8'd128, 8'd254};
    logic [7:0] bdv [5] = '{8'd1,   8'd255, 8'd200, 8'd129, 8'd127};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      launch(bdd[i], bdv[i], 1'b0);
      wait_done(30, n, ok);
      checks++;
      if (!ok || n != 9) begin
        errors++;
        $display("FAIL bound%0d_latency: got %0d cycles (seen=%0b) expected 9", i, n, ok);
      end
      pop_exp(e);
      checks++;
      if ({quotient, remainder, div_by_zero} !== e) begin
        errors++;
        $display("FAIL bound%0d_result %0d/%0d: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b",
                 i, bdd[i], bdv[i], quotient, remainder, div_by_zero, e.q, e.r, e.z);
      end
    end
  endtask

  task automatic test_div_by_zero;
    int n; bit ok; exp_t e;
    @(negedge clk);
    launch(8'd200, 8'd0, 1'b0);
    wait_done(30, n, ok);
    checks++;
    if (!ok || n != 1) begin
      errors++;
      $display("FAIL dbz_latency: got %0d cycles (seen=%0b) expected 1", n, ok);
    end
    pop_exp(e);
    checks++;
    if ({quotient, remainder, div_by_zero} !== e) begin
      errors++;
      $display("FAIL dbz_result: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.z);
    end
    @(negedge clk);
    launch(8'd9, 8'd3, 1'b0);
    wait_done(30, n, ok);
    checks++;
    if (!ok || n != 9) begin
      errors++;
      $display("FAIL dbz_clear_latency: got %0d cycles (seen=%0b) expected 9", n, ok);
    end
    pop_exp(e);
    checks++;
    if ({quotient, remainder, div_by_zero} !== e) begin
      errors++;
      $display("FAIL dbz_clear_result: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.z);
    end
  endtask

  task automatic test_start_ignored;
    int n; bit ok; exp_t e; int d0;
    @(negedge clk);
    d0 = done_cnt;
    launch(8'd100, 8'd7, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    dividend = 8'd50; divisor = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(30, n, ok);
    checks++;
    if (!ok || n != 4) begin
      errors++;
      $display("FAIL ignore_latency: got %0d cycles (seen=%0b) expected 4", n, ok);
    end
    pop_exp(e);
    checks++;
    if ({quotient, remainder, div_by_zero} !== e) begin
      errors++;
      $display("FAIL ignore_result: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.z);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL ignore_single_done: got %0d done pulses expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back;
    int n; bit ok; exp_t e;
    @(negedge clk);
    launch(8'd100, 8'd7, 1'b1);
    dividend = 8'd60;
    divisor  = 8'd8;
    sb.push_back(model(8'd60, 8'd8));
    wait_done(30, n, ok);
    checks++;
    if (!ok || n != 9) begin
      errors++;
      $display("FAIL b2b_first_latency: got %0d cycles (seen=%0b) expected 9", n, ok);
    end
    pop_exp(e);
    checks++;
    if ({quotient, remainder, div_by_zero} !== e) begin
      errors++;
      $display("FAIL b2b_first_result: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.z);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", busy, done);
    end
    wait_done(30, n, ok);
    checks++;
    if (!ok || n != 9) begin
      errors++;
      $display("FAIL b2b_second_latency: got %0d cycles (seen=%0b) expected 9", n, ok);
    end
    pop_exp(e);
    checks++;
    if ({quotient, remainder, div_by_zero} !== e) begin
      errors++;
      $display("FAIL b2b_second_result: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.z);
    end
  endtask

  task automatic test_reset_abort;
    int n; bit ok; exp_t e; int d0;
    @(negedge clk);
    d0 = done_cnt;
    launch(8'd100, 8'd7, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_during_rst: got busy=%b done=%b expected 0 0", busy, done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      errors++;
      $display("FAIL abort_cleared: got busy=%b done=%b q=%0d r=%0d z=%b expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses expected 0", done_cnt - d0);
    end
    launch(8'd77, 8'd10, 1'b0);
    wait_done(30, n, ok);
    checks++;
    if (!ok || n != 9) begin
      errors++;
      $display("FAIL abort_fresh_latency: got %0d cycles (seen=%0b) expected 9", n, ok);
    end
    pop_exp(e);
    checks++;
    if ({quotient, remainder, div_by_zero} !== e) begin
      errors++;
      $display("FAIL abort_fresh_result: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.z);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_by_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
